// File: rtl/stream_arb_pkg.sv
// Shared observer definitions: arbiter FSM states and source-ID header constants.
package observer_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE = 2'd0,
        ARB_HDR  = 2'd1,
        ARB_PASS = 2'd2
    } arb_state_e;

    // Source-ID header byte is this base OR'ed with the granted index.
    localparam logic [7:0]  SRCID_HDR_BASE = 8'hA0;
    localparam int unsigned ARB_MAX_SRC    = 8;

endpackage

// File: rtl/stream_arb_if.sv
// Stream bundle between the collector sources, the arbiter and the byte-wide sink.
// Member names are from the arbiter's point of view: i_* feed it, o_* come out of it.
interface stream_arb_if #(
    parameter int unsigned NUM_SRC = 2
);

    // Source side; source k occupies i_tdata[8k+7:8k]
    logic [NUM_SRC*8-1:0] i_tdata;
    logic [NUM_SRC-1:0]   i_tlast;
    logic [NUM_SRC-1:0]   i_tvalid;
    logic [NUM_SRC-1:0]   o_tready;

    // Sink side
    logic [7:0]           o_tdata;
    logic                 o_tlast;
    logic                 o_tvalid;
    logic                 i_tready;

    // Arbiter view
    modport slave (
        input  i_tdata,
        input  i_tlast,
        input  i_tvalid,
        output o_tready,
        output o_tdata,
        output o_tlast,
        output o_tvalid,
        input  i_tready
    );

    // Environment view (drives the sources and the sink ready)
    modport master (
        output i_tdata,
        output i_tlast,
        output i_tvalid,
        input  o_tready,
        input  o_tdata,
        input  o_tlast,
        input  o_tvalid,
        output i_tready
    );

endinterface

// File: rtl/stream_arb_rr_pick.sv
// Combinational rotating priority encoder: first requester searched from last+1 upward,
// wrapping modulo NUM_SRC.
module rr_pick #(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned IW      = $clog2(NUM_SRC)
) (
    input  logic [NUM_SRC-1:0] req_i,
    input  logic [IW-1:0]      last_i,
    output logic [IW-1:0]      win_o,
    output logic               any_o
);

    // One extra bit so last+offset never overflows before the wrap.
    localparam int unsigned SW = IW + 1;

    logic          found;
    logic [SW-1:0] cand;

    // Walk offsets 1..NUM_SRC; the first hit is the closest requester after last.
    always_comb begin
        win_o = '0;
        any_o = |req_i;
        found = 1'b0;
        cand  = '0;
        for (int unsigned i = 1; i <= NUM_SRC; i++) begin
            cand = {1'b0, last_i} + SW'(i);
            if (cand >= SW'(NUM_SRC)) begin
                cand = cand - SW'(NUM_SRC);
            end
            if (!found && req_i[cand[IW-1:0]]) begin
                win_o = cand[IW-1:0];
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_arb.sv
// Packet-level round-robin arbiter sharing one byte-wide AXI-Stream sink between
// NUM_SRC sources. A grant is held until the granted source's tlast beat is accepted.
// Optional macro STREAM_ARB_SRCID_EN: prefix each packet with one source-ID byte.
module stream_arb
    import observer_pkg::*;
#(
    parameter int unsigned NUM_SRC = 2,
    parameter int unsigned IW      = $clog2(NUM_SRC)
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    stream_arb_if.slave   bus,
    output logic [IW-1:0] o_grant,
    output logic          o_busy
);

    if (NUM_SRC < 2 || NUM_SRC > ARB_MAX_SRC) begin : g_bad_num_src
        $error("stream_arb: NUM_SRC must be in 2..%0d", ARB_MAX_SRC);
    end

    arb_state_e    state_q, state_d;
    logic [IW-1:0] grant_q, grant_d;
    logic [IW-1:0] last_q, last_d;

    logic [IW-1:0] pick_win;
    logic          pick_any;

    logic [7:0]    g_tdata;
    logic          g_tvalid;
    logic          g_tlast;

    rr_pick #(
        .NUM_SRC (NUM_SRC),
        .IW      (IW)
    ) u_pick (
        .req_i  (bus.i_tvalid),
        .last_i (last_q),
        .win_o  (pick_win),
        .any_o  (pick_any)
    );

    // Select the granted source's beat for the pass-through path.
    always_comb begin
        g_tdata  = bus.i_tdata[{grant_q, 3'b000} +: 8];
        g_tvalid = bus.i_tvalid[grant_q];
        g_tlast  = bus.i_tlast[grant_q];
    end

    // Next-state logic and sink/source outputs; everything idles low by default.
    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_d       = last_q;
        bus.o_tvalid = 1'b0;
        bus.o_tdata  = '0;
        bus.o_tlast  = 1'b0;
        bus.o_tready = '0;

        unique case (state_q)
            ARB_IDLE: begin
                // Requests are only looked at here, so a request raised during a
                // last beat is served one IDLE cycle later.
                if (pick_any) begin
                    grant_d = pick_win;
`ifdef STREAM_ARB_SRCID_EN
                    state_d = ARB_HDR;
`else
                    state_d = ARB_PASS;
`endif
                end
            end
`ifdef STREAM_ARB_SRCID_EN
            ARB_HDR: begin
                // Header is a pure function of grant_q, so it is stable until accepted.
                bus.o_tvalid = 1'b1;
                bus.o_tdata  = SRCID_HDR_BASE | 8'(grant_q);
                if (bus.i_tready) begin
                    state_d = ARB_PASS;
                end
            end
`endif
            ARB_PASS: begin
                bus.o_tvalid          = g_tvalid;
                bus.o_tdata           = g_tdata;
                bus.o_tlast           = g_tlast;
                bus.o_tready[grant_q] = bus.i_tready;
                if (g_tvalid && bus.i_tready && g_tlast) begin
                    last_d  = grant_q;
                    state_d = ARB_IDLE;
                end
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase
    end

    // State, grant and round-robin pointer; last resets to NUM_SRC-1 so source 0 wins first.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ARB_IDLE;
            grant_q <= '0;
            last_q  <= IW'(NUM_SRC - 1);
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            last_q  <= last_d;
        end
    end

    // Status outputs
    always_comb begin
        o_grant = grant_q;
        o_busy  = (state_q != ARB_IDLE);
    end

endmodule

// File: tb/tb_stream_arb.sv
// Self-checking bench for stream_arb with NUM_SRC=5: per-source drivers, a scoreboard of
// expected beats per source and a packet-level round-robin reference model.
// Honours STREAM_ARB_SRCID_EN when the build defines it.
`timescale 1ns/1ps
module tb_stream_arb;
    import observer_pkg::*;

    localparam int unsigned N  = 5;
    localparam int unsigned IW = $clog2(N);
`ifdef STREAM_ARB_SRCID_EN
    localparam bit HDR_EN = 1'b1;
`else
    localparam bit HDR_EN = 1'b0;
`endif

    logic          clk   = 1'b0;
    logic          rst_n = 1'b1;
    logic [IW-1:0] grant;
    logic          busy;

    stream_arb_if #(.NUM_SRC(N)) bus ();

    stream_arb #(
        .NUM_SRC (N)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus),
        .o_grant (grant),
        .o_busy  (busy)
    );

    always #5 clk = ~clk;

    typedef logic [8:0] beat_t;  // {tlast, tdata}

    beat_t txq  [N][$];  // beats still to be offered by each source
    beat_t expq [N][$];  // scoreboard: beats the sink must see from each source

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int gap_until [N];
    int rdy_mode = 0;    // 0: always ready, 1: pattern 1,0,0,1, 2: random
    bit rand_gap = 1'b0;

    // Reference model: packet in flight, header pending, current and previous grant
    bit          m_busy  = 1'b0;
    bit          m_hdr   = 1'b0;
    int          m_grant = 0;
    int          m_last  = N - 1;
    logic [N-1:0] acc    = '0;
    int          acc_cnt [N];
    int          gseq [$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Round-robin rule: closest requester after the previous grant, wrapping.
    function automatic int pick(input logic [N-1:0] req, input int last);
        for (int i = 1; i <= N; i++) begin
            int c;
            c = (last + i) % N;
            if (req[c]) return c;
        end
        return -1;
    endfunction

    // Monitor: mid-cycle, compare the sink/source outputs to the model and advance it.
    always @(negedge clk) begin
        logic [N-1:0] vld;
        logic [N-1:0] lst;
        logic         rdy;
        beat_t        b;
        int           w;
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_hdr   = 1'b0;
            m_grant = 0;
            m_last  = N - 1;
            acc     = '0;
        end else begin
            vld = bus.i_tvalid;
            lst = bus.i_tlast;
            rdy = bus.i_tready;
            acc = '0;
            chk("busy", busy, m_busy);
            chk("grant", grant, m_grant);
            if (!m_busy) begin
                chk("idle_tvalid", bus.o_tvalid, 0);
                chk("idle_tready", bus.o_tready, 0);
                w = pick(vld, m_last);
                if (w >= 0) begin
                    m_busy  = 1'b1;
                    m_hdr   = HDR_EN;
                    m_grant = w;
                    gseq.push_back(w);
                end
            end else if (m_hdr) begin
                chk("hdr_tvalid", bus.o_tvalid, 1);
                chk("hdr_tdata", bus.o_tdata, SRCID_HDR_BASE | 8'(m_grant));
                chk("hdr_tlast", bus.o_tlast, 0);
                chk("hdr_tready", bus.o_tready, 0);
                if (rdy) m_hdr = 1'b0;
            end else begin
                chk("pass_tvalid", bus.o_tvalid, vld[m_grant]);
                chk("pass_tready", bus.o_tready, rdy ? (32'd1 << m_grant) : 32'd0);
                if (vld[m_grant] && rdy) begin
                    acc[m_grant] = 1'b1;
                    acc_cnt[m_grant]++;
                    if (expq[m_grant].size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL pass_extra: beat 0x%0h from src %0d, expected none",
                                 bus.o_tdata, m_grant);
                    end else begin
                        b = expq[m_grant].pop_front();
                        chk("pass_tdata", bus.o_tdata, b[7:0]);
                        chk("pass_tlast", bus.o_tlast, b[8]);
                    end
                    if (lst[m_grant]) begin
                        m_last = m_grant;
                        m_busy = 1'b0;
                    end
                end
            end
        end
    end

    // Drivers: just after each rising edge retire accepted beats and present the next ones.
    always @(posedge clk) begin
        logic [N*8-1:0] d;
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        beat_t          hb;
        #1;
        cyc++;
        d = '0;
        v = '0;
        l = '0;
        for (int k = 0; k < N; k++) begin
            if (rst_n && acc[k] && txq[k].size() > 0) void'(txq[k].pop_front());
            if (txq[k].size() > 0 && cyc >= gap_until[k] &&
                !(rand_gap && $urandom_range(0, 3) == 0)) begin
                hb           = txq[k][0];
                v[k]         = 1'b1;
                d[k*8 +: 8]  = hb[7:0];
                l[k]         = hb[8];
            end
        end
        bus.i_tdata  = d;
        bus.i_tvalid = v;
        bus.i_tlast  = l;
        case (rdy_mode)
            1:       bus.i_tready = (cyc % 4 == 0) || (cyc % 4 == 3);
            2:       bus.i_tready = ($urandom_range(0, 3) != 0);
            default: bus.i_tready = 1'b1;
        endcase
    end

    task automatic push_beat(input int src, input logic [7:0] data, input logic last);
        txq[src].push_back({last, data});
        expq[src].push_back({last, data});
    endtask

    task automatic push_pkt(input int src, input int len);
        for (int i = 0; i < len; i++) push_beat(src, 8'($urandom), i == len - 1);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_grant", grant, 0);
        chk("rst_tvalid", bus.o_tvalid, 0);
        chk("rst_tready", bus.o_tready, 0);
        chk("rst_tdata", bus.o_tdata, 0);
        chk("rst_tlast", bus.o_tlast, 0);
        for (int k = 0; k < N; k++) begin
            txq[k].delete();
            expq[k].delete();
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
    endtask

    task automatic wait_drain(input int budget, input string name);
        int n;
        bit done;
        n = 0;
        do begin
            @(negedge clk);
            #1;
            done = !m_busy;
            for (int k = 0; k < N; k++) begin
                if (txq[k].size() != 0 || expq[k].size() != 0) done = 1'b0;
            end
            n++;
        end while (!done && n < budget);
        chk({name, "_drained"}, done, 1);
    endtask

    task automatic wait_beats(input int src, input int target, input string name);
        int n;
        n = 0;
        while (acc_cnt[src] < target && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk({name, "_reached"}, acc_cnt[src] >= target, 1);
    endtask

    task automatic chk_gseq(input string name, input int base, input int idx, input int exp);
        if (base + idx < gseq.size()) chk(name, gseq[base + idx], exp);
        else chk({name, "_missing"}, gseq.size(), base + idx + 1);
    endtask

    initial begin
        int base;
        int c1;
        #2 assert_reset();

        // Single source, bytes 11,22,33
        @(posedge clk); #3;
        base = gseq.size();
        push_beat(0, 8'h11, 1'b0);
        push_beat(0, 8'h22, 1'b0);
        push_beat(0, 8'h33, 1'b1);
        wait_drain(100, "single");
        chk("single_count", gseq.size() - base, 1);
        chk_gseq("single_grant", base, 0, 0);

        // Contention straight after reset: three packets per source alternate 0,1
        assert_reset();
        @(posedge clk); #3;
        base = gseq.size();
        for (int p = 0; p < 3; p++) begin
            push_pkt(0, 1 + $urandom_range(0, 3));
            push_pkt(1, 1 + $urandom_range(0, 3));
        end
        wait_drain(400, "contend");
        chk("contend_count", gseq.size() - base, 6);
        for (int i = 0; i < 6; i++) chk_gseq("contend_grant", base, i, i % 2);

        // Sink backpressure pattern 1,0,0,1 with another source waiting
        rdy_mode = 1;
        @(posedge clk); #3;
        base = gseq.size();
        push_pkt(0, 6);
        push_pkt(1, 3);
        wait_drain(200, "bp");
        chk("bp_count", gseq.size() - base, 2);
        chk_gseq("bp_grant", base, 0, 0);
        chk_gseq("bp_grant", base, 1, 1);
        rdy_mode = 0;

        // Randomized traffic: random sources, lengths, source gaps and sink stalls
        rdy_mode = 2;
        rand_gap = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #3;
            push_pkt($urandom_range(0, N - 1), $urandom_range(1, 6));
            repeat ($urandom_range(0, 6)) @(posedge clk);
        end
        wait_drain(4000, "random");
        rand_gap = 1'b0;
        rdy_mode = 0;

        // Granted src1 stalls 5 cycles mid-packet while src0 requests
        @(posedge clk); #3;
        base = gseq.size();
        c1 = acc_cnt[1];
        push_pkt(1, 4);
        wait_beats(1, c1 + 1, "gap_first_beat");
        gap_until[1] = cyc + 6;
        push_pkt(0, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("gap_busy", busy, 1);
            chk("gap_grant", grant, 1);
            chk("gap_src0_tready", bus.o_tready[0], 0);
        end
        wait_drain(200, "gap");
        chk("gap_count", gseq.size() - base, 2);
        chk_gseq("gap_order", base, 0, 1);
        chk_gseq("gap_order", base, 1, 0);

        // Asynchronous reset in the middle of a src1 packet
        @(posedge clk); #3;
        c1 = acc_cnt[1];
        for (int i = 0; i < 8; i++) push_beat(1, 8'(8'h81 + i), i == 7);
        wait_beats(1, c1 + 2, "midrst_beats");
        #1 assert_reset();
        @(posedge clk); #3;
        base = gseq.size();
        push_pkt(0, 1);
        push_pkt(1, 1);
        wait_drain(100, "midrst");
        chk_gseq("midrst_first", base, 0, 0);
        chk_gseq("midrst_second", base, 1, 1);

        // Fairness: every source requests two single-beat packets back to back
        assert_reset();
        @(posedge clk); #3;
        base = gseq.size();
        for (int r = 0; r < 2; r++) begin
            for (int k = 0; k < N; k++) push_pkt(k, 1);
        end
        wait_drain(200, "fair");
        chk("fair_count", gseq.size() - base, 2 * N);
        for (int i = 0; i < 2 * N; i++) chk_gseq("fair_grant", base, i, i % N);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
